lsm_pipe: RTL and testbench
===========================

# lsm_pipe

Pipelined load/store unit between the execute stage and write-back, successor to the single-request memory stage. Accepts one instruction per cycle, issues pipelined Wishbone B4 requests without waiting for earlier acknowledges, and tracks up to DEPTH instructions in flight. It aligns store data, generates byte selects, sign/zero-extends load data, and retires every instruction, memory or not, to write-back in program order.

## Interface
- DEPTH, 4, in-flight entries; power of two, ≥ 2
- ADDR_WIDTH, 32, Wishbone address width; low ADDR_WIDTH bits of alu_result_i
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- input_ready_o  out  1  entry can be accepted this cycle
- input_valid_i  in  1  execute-stage instruction valid
- alu_result_i  in  32  memory address, or pass-through result when enable_i=0
- enable_i  in  1  instruction is a load/store
- write_i  in  1  1 = store, 0 = load
- write_data_i  in  32  store data, right-aligned
- size_i  in  2  0 byte, 1 half, 2 word; 3 is treated as word
- unsigned_load_i  in  1  zero-extend instead of sign-extend
- reg_write_i, reg_addr_i  in  1, 5  write-back pass-through
- wb_adr_o  out  ADDR_WIDTH  address
- wb_dat_i / wb_dat_o  in / out  32  read / write data
- wb_we_o, wb_stb_o, wb_cyc_o  out  1  Wishbone controls
- wb_sel_o  out  4  byte lanes
- wb_ack_i, wb_stall_i  in  1  Wishbone responses
- output_valid_o  out  1  one retired instruction this cycle, no backpressure
- reg_write_o, reg_addr_o, reg_data_o  out  1, 5, 32  write-back
- misaligned_o  out  1  only with LSM_MISALIGN_TRAP_EN; tied 0 otherwise

## Operation
- Circular FIFO of DEPTH entries, with head, tail and count. Each entry holds: is_mem, write, size, byte offset, unsigned, reg_write, reg_addr, data, done.
- Accept condition: input_valid_i && input_ready_o, where input_ready_o = (count < DEPTH) && !(wb_stb_o && wb_stall_i). input_ready_o is combinational and forced 0 while rst_ni is low.
- Entry with enable_i=0: stored with done=1 and data=alu_result_i.
- Entry with enable_i=1: stored with done=0 and a bus request is registered:
  - wb_adr_o = address with the low 2 bits cleared.
  - wb_sel_o is 0001, 0011 or 1111 shifted left by addr[1:0].
  - wb_dat_o = write_data_i shifted left by 8*addr[1:0].
- wb_stb_o stays high while wb_stall_i=1. A request is issued on any cycle with stb=1 and stall=0.
  - A new request may load in that same cycle, giving back-to-back issue.
  - Otherwise stb drops.
- wb_cyc_o is high whenever stb=1 or any issued request is unacknowledged. It drops the cycle after the last ack.
- On ack, the oldest issued, not-done memory entry (priority search from head) gets done=1.
  - Loads: data = (wb_dat_i >> 8*offset), truncated to size, then sign- or zero-extended.
  - Stores: data = 0.
- An ack with no issued, unacknowledged request is ignored.
- Retire: when the head entry has done=1, pop it and register output_valid_o, reg_* and data. At most one retire per cycle.
- Push and pop may occur in the same cycle. The count check uses the registered count, so a full FIFO refuses input even when it pops in that cycle.
- Reset (async) clears FIFO, pointers, stb, cyc and all outputs immediately. Acks arriving after reset are ignored.

## Timing
- Reset values: every output 0; input_ready_o goes to 1 in the first cycle after rst_ni deasserts.
- Non-memory instruction accepted in cycle N with an empty FIFO: output_valid_o in N+1.
- Memory instruction accepted in N: stb high in N+1. With stall=0 and ack in N+2, output_valid_o is in N+3.
- Each stall cycle delays issue by one cycle.
- Retirement order is acceptance order. A non-memory entry behind a pending load waits until that load retires.
- Sustained throughput is one instruction per cycle with zero stall and one-cycle ack latency, while count < DEPTH.

## Configuration
- LSM_MISALIGN_TRAP_EN defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, issues no bus cycle.
  - The entry is stored done=1, reg_write=0, and retires in order with misaligned_o=1 on its output_valid_o cycle.
- LSM_MISALIGN_TRAP_EN undefined:
  - Offset is forced to the natural alignment: half uses addr[1], word uses 0.
  - The access proceeds normally and misaligned_o is constant 0.

## Test plan
- Load byte at 0x1003, wb_dat_i=0x80FF_FF_FF, unsigned=0 -> wb_sel_o=1000, reg_data_o=0xFFFF_FF80 at N+3.
- Store half 0xABCD at 0x2002 -> wb_adr_o=0x2000, wb_sel_o=1100, wb_dat_o=0xABCD_0000, wb_we_o=1, output_valid_o with reg_write_o=0.
- Four loads back-to-back with DEPTH=4 and ack delayed 3 cycles -> four consecutive stb issues, input_ready_o=0 at count=4, results retire in order.
- Load stalled 2 cycles, then a non-memory op (alu 0x55, rd 7) -> stb held 3 cycles; the op retires one cycle after the load, never before.
- Misaligned word at 0x3001 with the macro -> no stb, misaligned_o=1; without the macro -> wb_adr_o=0x3000, sel=1111.
- rst_ni low while 2 requests are outstanding -> stb/cyc/output_valid_o 0 immediately, then stray acks after release produce no output.

Source files
------------

// File: rtl/lsm_pipe.sv
// lsm_pipe: pipelined Wishbone B4 load/store unit with in-order retirement.
// Define LSM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module lsm_pipe #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic                  input_ready_o,
   input  logic                  input_valid_i,
   input  logic [31:0]           alu_result_i,
   input  logic                  enable_i,
   input  logic                  write_i,
   input  logic [31:0]           write_data_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_load_i,
   input  logic                  reg_write_i,
   input  logic [4:0]            reg_addr_i,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_we_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   output logic [3:0]            wb_sel_o,
   input  logic                  wb_ack_i,
   input  logic                  wb_stall_i,
   output logic                  output_valid_o,
   output logic                  reg_write_o,
   output logic [4:0]            reg_addr_o,
   output logic [31:0]           reg_data_o,
   output logic                  misaligned_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef struct packed {
      logic        is_mem;
      logic        we;
      logic [1:0]  size;
      logic [1:0]  off;
      logic        uns;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        done;
      logic        mis;
   } ent_t;

   ent_t                  r_q [DEPTH];
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         r_outst;
   logic                  r_stb;
   logic                  r_we;
   logic [3:0]            r_sel;
   logic [31:0]           r_dat;
   logic [ADDR_WIDTH-1:0] r_adr;
   logic                  r_ovalid;
   logic                  r_rw;
   logic [4:0]            r_rd;
   logic [31:0]           r_data;

   logic [1:0]            w_off;
   logic                  w_mis;
   logic [3:0]            w_base;
   logic                  w_ready;
   logic                  w_push;
   logic                  w_req;
   logic                  w_byp;
   logic                  w_wr;
   logic                  w_pop;
   logic                  w_issue;
   logic                  w_hit;
   logic                  w_ack;
   logic                  w_hack;
   logic [PW-1:0]         w_idx;
   logic [PW-1:0]         w_scan;
   logic [31:0]           w_ack_data;
   ent_t                  w_new;

   function automatic logic [31:0] f_load(
      input logic [31:0] d,
      input logic [1:0]  off,
      input logic [1:0]  sz,
      input logic        uns
   );
      logic [31:0] s;
      s = d >> {off, 3'b000};
      unique case (sz)
         2'd0:    return {{24{s[7] & ~uns}}, s[7:0]};
         2'd1:    return {{16{s[15] & ~uns}}, s[15:0]};
         default: return s;
      endcase
   endfunction

   // Offsets are forced to natural alignment; a trapped access never issues.
   always_comb begin
      w_off  = 2'b00;
      w_base = 4'b1111;
      w_mis  = 1'b0;
      unique case (size_i)
         2'd0: begin
            w_off  = alu_result_i[1:0];
            w_base = 4'b0001;
         end
         2'd1: begin
            w_off  = {alu_result_i[1], 1'b0};
            w_base = 4'b0011;
         end
         default: begin
            w_off  = 2'b00;
            w_base = 4'b1111;
         end
      endcase
`ifdef LSM_MISALIGN_TRAP_EN
      if (size_i == 2'd1)
         w_mis = enable_i && alu_result_i[0];
      else if (size_i[1])
         w_mis = enable_i && (alu_result_i[1:0] != 2'b00);
`endif
   end

   always_comb begin
      w_new        = '0;
      w_new.is_mem = enable_i && !w_mis;
      w_new.we     = write_i;
      w_new.size   = size_i;
      w_new.off    = w_off;
      w_new.uns    = unsigned_load_i;
      w_new.rw     = reg_write_i && !w_mis;
      w_new.rd     = reg_addr_i;
      w_new.data   = enable_i ? 32'd0 : alu_result_i;
      w_new.done   = !enable_i || w_mis;
      w_new.mis    = w_mis;
   end

   assign w_ready = rst_ni && (r_count < CW'(DEPTH))
                    && !(r_stb && wb_stall_i);
   assign w_push  = input_valid_i && w_ready;
   assign w_req   = w_push && w_new.is_mem;
   assign w_issue = r_stb && !wb_stall_i;

   // Acks return in issue order, so the oldest pending memory entry owns it.
   always_comb begin
      w_hit  = 1'b0;
      w_idx  = r_head;
      w_scan = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_scan = r_head + PW'(i);
         if (!w_hit && (CW'(i) < r_count)
             && r_q[w_scan].is_mem && !r_q[w_scan].done) begin
            w_hit = 1'b1;
            w_idx = w_scan;
         end
      end
   end

   assign w_ack      = wb_ack_i && (r_outst != '0) && w_hit;
   assign w_ack_data = r_q[w_idx].we ? 32'd0 :
                       f_load(wb_dat_i, r_q[w_idx].off,
                              r_q[w_idx].size, r_q[w_idx].uns);
   assign w_hack     = w_ack && (w_idx == r_head);
   assign w_pop      = (r_count != '0) && (r_q[r_head].done || w_hack);
   assign w_byp      = w_push && (r_count == '0) && w_new.done;
   assign w_wr       = w_push && !w_byp;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++)
            r_q[i] <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_outst  <= '0;
         r_ovalid <= 1'b0;
         r_rw     <= 1'b0;
         r_rd     <= '0;
         r_data   <= '0;
      end else begin
         if (w_ack) begin
            r_q[w_idx].done <= 1'b1;
            r_q[w_idx].data <= w_ack_data;
         end
         if (w_wr) begin
            r_q[r_tail] <= w_new;
            r_tail      <= r_tail + 1'b1;
         end
         if (w_pop)
            r_head <= r_head + 1'b1;
         r_count  <= r_count + CW'(w_wr) - CW'(w_pop);
         r_outst  <= r_outst + CW'(w_issue) - CW'(w_ack);
         r_ovalid <= w_pop || w_byp;
         if (w_pop) begin
            r_rw   <= r_q[r_head].rw;
            r_rd   <= r_q[r_head].rd;
            r_data <= w_hack ? w_ack_data : r_q[r_head].data;
         end else if (w_byp) begin
            r_rw   <= w_new.rw;
            r_rd   <= w_new.rd;
            r_data <= w_new.data;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stb <= 1'b0;
         r_we  <= 1'b0;
         r_sel <= '0;
         r_dat <= '0;
         r_adr <= '0;
      end else if (w_req) begin
         r_stb <= 1'b1;
         r_we  <= write_i;
         r_sel <= w_base << w_off;
         r_dat <= write_data_i << {w_off, 3'b000};
         r_adr <= {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (w_issue) begin
         r_stb <= 1'b0;
      end
   end

`ifdef LSM_MISALIGN_TRAP_EN
   logic r_mis;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         r_mis <= 1'b0;
      else if (w_pop)
         r_mis <= r_q[r_head].mis;
      else if (w_byp)
         r_mis <= w_new.mis;
      else
         r_mis <= 1'b0;
   end

   assign misaligned_o = r_mis;
`else
   assign misaligned_o = 1'b0;
`endif

   assign input_ready_o  = w_ready;
   assign wb_adr_o       = r_adr;
   assign wb_dat_o       = r_dat;
   assign wb_we_o        = r_we;
   assign wb_stb_o       = r_stb;
   assign wb_sel_o       = r_sel;
   assign wb_cyc_o       = r_stb || (r_outst != '0);
   assign output_valid_o = r_ovalid;
   assign reg_write_o    = r_rw;
   assign reg_addr_o     = r_rd;
   assign reg_data_o     = r_data;

endmodule

// File: tb/tb_lsm_pipe.sv
// tb_lsm_pipe: directed self-checking bench for lsm_pipe.
// Covers alignment, extension, back-to-back issue, stalls, ordering, reset.
module tb_lsm_pipe;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        rdy;
   logic        in_valid;
   logic [31:0] alu;
   logic        en;
   logic        wr;
   logic [31:0] wdata;
   logic [1:0]  size;
   logic        uns;
   logic        rw;
   logic [4:0]  rd;
   logic [31:0] adr;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        we;
   logic        stb;
   logic        cyc;
   logic [3:0]  sel;
   logic        ack;
   logic        stall;
   logic        ovalid;
   logic        orw;
   logic [4:0]  ord;
   logic [31:0] odata;
   logic        mis;

   int n_err = 0;
   int n_chk = 0;

   lsm_pipe #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .input_ready_o  (rdy),
      .input_valid_i  (in_valid),
      .alu_result_i   (alu),
      .enable_i       (en),
      .write_i        (wr),
      .write_data_i   (wdata),
      .size_i         (size),
      .unsigned_load_i(uns),
      .reg_write_i    (rw),
      .reg_addr_i     (rd),
      .wb_adr_o       (adr),
      .wb_dat_i       (dat_i),
      .wb_dat_o       (dat_o),
      .wb_we_o        (we),
      .wb_stb_o       (stb),
      .wb_cyc_o       (cyc),
      .wb_sel_o       (sel),
      .wb_ack_i       (ack),
      .wb_stall_i     (stall),
      .output_valid_o (ovalid),
      .reg_write_o    (orw),
      .reg_addr_o     (ord),
      .reg_data_o     (odata),
      .misaligned_o   (mis)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic r,
                        input logic [4:0] d);
      in_valid = 1'b1;
      en       = e;
      wr       = w;
      size     = sz;
      uns      = u;
      alu      = a;
      wdata    = wd;
      rw       = r;
      rd       = d;
   endtask

   task automatic mem_op(input string tag, input logic w,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input logic [31:0] eadr,
                         input logic [3:0] esel, input logic [31:0] ewd,
                         input logic [31:0] edata);
      drive(1'b1, w, sz, u, a, wd, !w, 5'd5);
      tick();
      in_valid = 1'b0;
      chk({tag, "_stb"}, stb, 1);
      chk({tag, "_adr"}, adr, eadr);
      chk({tag, "_sel"}, sel, esel);
      chk({tag, "_we"}, we, w);
      if (w)
         chk({tag, "_wdat"}, dat_o, ewd);
      chk({tag, "_early"}, ovalid, 0);
      tick();
      chk({tag, "_stb_drop"}, stb, 0);
      chk({tag, "_cyc"}, cyc, 1);
      ack   = 1'b1;
      dat_i = rdat;
      tick();
      ack = 1'b0;
      chk({tag, "_ovalid"}, ovalid, 1);
      chk({tag, "_data"}, odata, edata);
      chk({tag, "_rw"}, orw, !w);
      chk({tag, "_mis"}, mis, 0);
      tick();
      chk({tag, "_idle_cyc"}, cyc, 0);
      chk({tag, "_idle_ov"}, ovalid, 0);
   endtask

   initial begin
      rst_ni   = 1'b0;
      in_valid = 1'b0;
      en = 1'b0; wr = 1'b0; size = 2'd0; uns = 1'b0;
      alu = '0; wdata = '0; rw = 1'b0; rd = '0;
      ack = 1'b0; stall = 1'b0; dat_i = '0;
      #2;
      chk("rst_rdy", rdy, 0);
      chk("rst_stb", stb, 0);
      chk("rst_cyc", cyc, 0);
      chk("rst_ov", ovalid, 0);
      chk("rst_data", odata, 0);
      tick();
      tick();
      rst_ni = 1'b1;
      #1;
      chk("rdy_up", rdy, 1);

      mem_op("lb", 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF_FFFF,
             32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
      mem_op("sh", 1'b1, 2'd1, 1'b0, 32'h2002, 32'hABCD, 32'hDEAD_BEEF,
             32'h2000, 4'b1100, 32'hABCD_0000, 32'h0);
      mem_op("lhu", 1'b0, 2'd1, 1'b1, 32'h0402, 32'h0, 32'h8765_4321,
             32'h0400, 4'b1100, 32'h0, 32'h0000_8765);
      mem_op("lh", 1'b0, 2'd1, 1'b0, 32'h0400, 32'h0, 32'h1234_F00D,
             32'h0400, 4'b0011, 32'h0, 32'hFFFF_F00D);
      mem_op("lbu", 1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 32'h0000_9A00,
             32'h1000, 4'b0010, 32'h0, 32'h0000_009A);
      mem_op("sb", 1'b1, 2'd0, 1'b0, 32'h0041, 32'h5A, 32'h0,
             32'h0040, 4'b0010, 32'h0000_5A00, 32'h0);

      // Non-memory op with an empty queue retires the next cycle.
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h1234, 32'h0, 1'b1, 5'd3);
      tick();
      in_valid = 1'b0;
      chk("alu_ov", ovalid, 1);
      chk("alu_data", odata, 32'h1234);
      chk("alu_rd", ord, 3);
      chk("alu_rw", orw, 1);
      chk("alu_nostb", stb, 0);
      tick();
      chk("alu_done", ovalid, 0);

      // Four back-to-back loads, each ack three cycles after its issue.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100 + 32'(4 * k), 32'h0,
               1'b1, 5'(k + 1));
         chk($sformatf("b2b_rdy%0d", k), rdy, 1);
         tick();
         chk($sformatf("b2b_stb%0d", k), stb, 1);
      end
      in_valid = 1'b0;
      chk("b2b_full", rdy, 0);
      chk("b2b_ov0", ovalid, 0);
      for (int k = 0; k < 4; k++) begin
         ack   = 1'b1;
         dat_i = 32'hA000_0000 + 32'(k);
         tick();
         if (k == 0)
            chk("b2b_stb_off", stb, 0);
         chk($sformatf("b2b_ov%0d", k), ovalid, 1);
         chk($sformatf("b2b_rd%0d", k), ord, 32'(k + 1));
         chk($sformatf("b2b_dat%0d", k), odata, 32'hA000_0000 + 32'(k));
      end
      ack = 1'b0;
      chk("b2b_cyc", cyc, 0);
      tick();
      chk("b2b_end", ovalid, 0);

      // Stalled load followed by an ALU op that must not overtake it.
      stall = 1'b1;
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 5'd9);
      tick();
      chk("stl_stb1", stb, 1);
      chk("stl_rdy1", rdy, 0);
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h55, 32'h0, 1'b1, 5'd7);
      tick();
      chk("stl_stb2", stb, 1);
      chk("stl_rdy2", rdy, 0);
      chk("stl_ov2", ovalid, 0);
      tick();
      chk("stl_stb3", stb, 1);
      chk("stl_ov3", ovalid, 0);
      stall = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("stl_stb4", stb, 0);
      chk("stl_ov4", ovalid, 0);
      ack   = 1'b1;
      dat_i = 32'h1234_5678;
      tick();
      ack = 1'b0;
      chk("stl_ld_ov", ovalid, 1);
      chk("stl_ld_rd", ord, 9);
      chk("stl_ld_dat", odata, 32'h1234_5678);
      tick();
      chk("stl_op_ov", ovalid, 1);
      chk("stl_op_rd", ord, 7);
      chk("stl_op_dat", odata, 32'h55);
      tick();
      chk("stl_end", ovalid, 0);

`ifdef LSM_MISALIGN_TRAP_EN
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 1'b1, 5'd4);
      tick();
      in_valid = 1'b0;
      chk("mis_stb", stb, 0);
      chk("mis_cyc", cyc, 0);
      chk("mis_ov", ovalid, 1);
      chk("mis_flag", mis, 1);
      chk("mis_rw", orw, 0);
      tick();
      chk("mis_clr", mis, 0);
      chk("mis_ov_clr", ovalid, 0);
`else
      mem_op("lw_mis", 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'hCAFE_BABE,
             32'h3000, 4'b1111, 32'h0, 32'hCAFE_BABE);
`endif

      // Reset with two requests outstanding; later acks must be ignored.
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 1'b1, 5'd1);
      tick();
      alu = 32'h504;
      rd  = 5'd2;
      tick();
      alu = 32'h508;
      rd  = 5'd3;
      tick();
      in_valid = 1'b0;
      ack      = 1'b1;
      dat_i    = 32'h77;
      tick();
      ack = 1'b0;
      chk("rs_pre_ov", ovalid, 1);
      chk("rs_pre_dat", odata, 32'h77);
      chk("rs_pre_cyc", cyc, 1);
      rst_ni = 1'b0;
      #1;
      chk("rs_stb", stb, 0);
      chk("rs_cyc", cyc, 0);
      chk("rs_ov", ovalid, 0);
      chk("rs_rdy", rdy, 0);
      tick();
      rst_ni = 1'b1;
      ack    = 1'b1;
      dat_i  = 32'hFFFF_FFFF;
      tick();
      chk("rs_stray1", ovalid, 0);
      tick();
      ack = 1'b0;
      chk("rs_stray2", ovalid, 0);
      chk("rs_cyc_after", cyc, 0);
      chk("rs_rdy_after", rdy, 1);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
